// File: rtl/datapath_bip3.sv
// BIP-3 accumulator datapath: configurable-width ACC, extended ALU with registered
// Z/N/C/V flags, and an iterative shift-add multiplier with busy/done handshake.
module datapath_bip3 #(
  parameter int DATA_W    = 16,
  parameter int OPERAND_W = 11,
  parameter int SIGN_EXT  = 1
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [1:0]           selA_i,
  input  logic                 selB_i,
  input  logic                 WRACC_i,
  input  logic [3:0]           op_i,
  input  logic [OPERAND_W-1:0] operand_i,
  input  logic [DATA_W-1:0]    dm_out_data,
  output logic [DATA_W-1:0]    dm_in_data,
  output logic [OPERAND_W-1:0] dm_addr,
  output logic [DATA_W-1:0]    ext_o,
  output logic                 flagZ_o,
  output logic                 flagN_o,
  output logic                 flagC_o,
  output logic                 flagV_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1001;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e                r_state;
  logic [DATA_W-1:0]     r_acc;
  logic                  r_z, r_n, r_c, r_v;
  logic                  r_busy, r_done;
  logic [2*DATA_W-1:0]   r_mcand;
  logic [DATA_W-1:0]     r_mplier;
  logic [2*DATA_W-1:0]   r_prod;
  logic [CNT_W-1:0]      r_cnt;

  logic [DATA_W-1:0]     w_ext;
  logic [DATA_W-1:0]     w_b;
  logic [SH_W-1:0]       w_shamt;
  logic [DATA_W:0]       w_sum, w_diff, w_shl, w_shr;
  logic [2*DATA_W-1:0]   w_prod_next;
  logic [DATA_W-1:0]     w_res;
  logic                  w_c, w_v, w_acc_we, w_flags_we;

  for (genvar g = 0; g < DATA_W; g++) begin : g_ext
    if (g < OPERAND_W) begin : g_pass
      assign w_ext[g] = operand_i[g];
    end else begin : g_fill
      assign w_ext[g] = (SIGN_EXT != 0) ? operand_i[OPERAND_W-1] : 1'b0;
    end
  end

  assign ext_o      = w_ext;
  assign dm_addr    = operand_i;
  assign dm_in_data = r_acc;
  assign flagZ_o    = r_z;
  assign flagN_o    = r_n;
  assign flagC_o    = r_c;
  assign flagV_o    = r_v;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

  assign w_b     = selB_i ? w_ext : dm_out_data;
  assign w_shamt = w_b[SH_W-1:0];
  assign w_sum   = {1'b0, r_acc} + {1'b0, w_b};
  assign w_diff  = {1'b0, r_acc} - {1'b0, w_b};
  // The extra bit on each shift catches the last bit shifted out (0 for amount 0).
  assign w_shl   = {1'b0, r_acc} << w_shamt;
  assign w_shr   = {r_acc, 1'b0} >> w_shamt;
  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_res      = r_acc;
    w_c        = 1'b0;
    w_v        = 1'b0;
    w_acc_we   = 1'b1;
    w_flags_we = 1'b1;
    case (op_i)
      OP_ADD: begin
        w_res = w_sum[DATA_W-1:0];
        w_c   = w_sum[DATA_W];
        w_v   = (r_acc[DATA_W-1] == w_b[DATA_W-1]) && (w_res[DATA_W-1] != r_acc[DATA_W-1]);
      end
      OP_SUB, OP_CMP: begin
        w_res    = w_diff[DATA_W-1:0];
        w_c      = w_diff[DATA_W];
        w_v      = (r_acc[DATA_W-1] != w_b[DATA_W-1]) && (w_res[DATA_W-1] != r_acc[DATA_W-1]);
        w_acc_we = (op_i == OP_SUB);
      end
      OP_AND: w_res = r_acc & w_b;
      OP_OR:  w_res = r_acc | w_b;
      OP_XOR: w_res = r_acc ^ w_b;
      OP_NOT: w_res = ~r_acc;
      OP_SHL: begin
        w_res = w_shl[DATA_W-1:0];
        w_c   = w_shl[DATA_W];
      end
      OP_SHR: begin
        w_res = w_shr[DATA_W:1];
        w_c   = w_shr[0];
      end
      default: begin
        w_acc_we   = 1'b0;
        w_flags_we = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (WRACC_i) begin
            case (selA_i)
              2'b00: r_acc <= dm_out_data;
              2'b01: r_acc <= w_ext;
              2'b10: begin
                if (op_i == OP_MUL) begin
                  r_mcand  <= {{DATA_W{1'b0}}, w_b};
                  r_mplier <= r_acc;
                  r_prod   <= '0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= S_RUN;
                end else begin
                  if (w_acc_we) r_acc <= w_res;
                  if (w_flags_we) begin
                    r_z <= (w_res == '0);
                    r_n <= w_res[DATA_W-1];
                    r_c <= w_c;
                    r_v <= w_v;
                  end
                end
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          r_prod   <= w_prod_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_acc   <= w_prod_next[DATA_W-1:0];
            r_z     <= (w_prod_next[DATA_W-1:0] == '0);
            r_n     <= w_prod_next[DATA_W-1];
            r_c     <= |w_prod_next[2*DATA_W-1:DATA_W];
            r_v     <= |w_prod_next[2*DATA_W-1:DATA_W];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_bip3.sv
// Randomised and directed bench for datapath_bip3 (16-bit data, 11-bit operand)
// against an arithmetic reference model of the accumulator, flags and multiplier.
module tb_datapath_bip3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel_a;
  logic        sel_b, wracc;
  logic [3:0]  op;
  logic [10:0] operand;
  logic [15:0] dm_rd;

  logic [15:0] s1_acc, s1_ext, s0_acc, s0_ext;
  logic [10:0] s1_addr, s0_addr;
  logic        s1_z, s1_n, s1_c, s1_v, s1_busy, s1_done;
  logic        s0_z, s0_n, s0_c, s0_v, s0_busy, s0_done;

  int n_checks = 0;
  int n_errors = 0;

  int     m_acc;
  bit     m_z, m_n, m_c, m_v, m_done;
  int     m_busy_left;
  longint m_prod;

  always #5 clk = ~clk;

  datapath_bip3 #(.DATA_W(16), .OPERAND_W(11), .SIGN_EXT(1)) dut_sx (
    .clock_i(clk), .reset_i(rst), .selA_i(sel_a), .selB_i(sel_b), .WRACC_i(wracc),
    .op_i(op), .operand_i(operand), .dm_out_data(dm_rd), .dm_in_data(s1_acc),
    .dm_addr(s1_addr), .ext_o(s1_ext), .flagZ_o(s1_z), .flagN_o(s1_n),
    .flagC_o(s1_c), .flagV_o(s1_v), .busy_o(s1_busy), .done_o(s1_done));

  datapath_bip3 #(.DATA_W(16), .OPERAND_W(11), .SIGN_EXT(0)) dut_zx (
    .clock_i(clk), .reset_i(rst), .selA_i(sel_a), .selB_i(sel_b), .WRACC_i(wracc),
    .op_i(op), .operand_i(operand), .dm_out_data(dm_rd), .dm_in_data(s0_acc),
    .dm_addr(s0_addr), .ext_o(s0_ext), .flagZ_o(s0_z), .flagN_o(s0_n),
    .flagC_o(s0_c), .flagV_o(s0_v), .busy_o(s0_busy), .done_o(s0_done));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ext_val(input int opd, input bit sx);
    if (sx && opd >= 1024) return opd + 65536 - 2048;
    return opd;
  endfunction

  function automatic int to_signed(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  task automatic set_flags(input int r, input bit c, input bit v);
    m_z = (r == 0);
    m_n = (r >= 32768);
    m_c = c;
    m_v = v;
  endtask

  task automatic model_exec();
    int a, b, amt, r, sd;
    bit c, v, wr_acc;
    a = m_acc;
    b = sel_b ? ext_val(int'(operand), 1'b1) : int'(dm_rd);
    amt = b % 16;
    c = 1'b0;
    v = 1'b0;
    wr_acc = 1'b1;
    r = a;
    case (op)
      4'd0: begin
        r  = a + b;
        c  = (r > 65535);
        sd = to_signed(a) + to_signed(b);
        v  = (sd > 32767) || (sd < -32768);
        r  = r % 65536;
      end
      4'd1, 4'd9: begin
        c  = (a < b);
        sd = to_signed(a) - to_signed(b);
        v  = (sd > 32767) || (sd < -32768);
        r  = (a - b + 65536) % 65536;
        wr_acc = (op == 4'd1);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = 65535 - a;
      4'd6: begin
        r = (a << amt) % 65536;
        c = (amt != 0) && ((a >> (16 - amt)) % 2 == 1);
      end
      4'd7: begin
        r = a >> amt;
        c = (amt != 0) && ((a >> (amt - 1)) % 2 == 1);
      end
      4'd8: begin
        m_prod      = longint'(a) * longint'(b);
        m_busy_left = 16;
        return;
      end
      default: return;
    endcase
    if (wr_acc) m_acc = r;
    set_flags(r, c, v);
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) begin
        m_acc  = int'(m_prod % 64'd65536);
        set_flags(m_acc, m_prod >= 65536, m_prod >= 65536);
        m_done = 1'b1;
      end
    end else if (wracc) begin
      case (sel_a)
        2'd0: m_acc = int'(dm_rd);
        2'd1: m_acc = ext_val(int'(operand), 1'b1);
        2'd2: model_exec();
        default: ;
      endcase
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
    m_done = 1'b0;
    m_busy_left = 0;
    m_prod = 0;
  endtask

  task automatic compare_all();
    check("acc",     32'(s1_acc),  32'(m_acc));
    check("z",       32'(s1_z),    32'(m_z));
    check("n",       32'(s1_n),    32'(m_n));
    check("c",       32'(s1_c),    32'(m_c));
    check("v",       32'(s1_v),    32'(m_v));
    check("busy",    32'(s1_busy), 32'(m_busy_left > 0));
    check("done",    32'(s1_done), 32'(m_done));
    check("addr",    32'(s1_addr), 32'(operand));
    check("ext_sx",  32'(s1_ext),  32'(ext_val(int'(operand), 1'b1)));
    check("ext_zx",  32'(s0_ext),  32'(ext_val(int'(operand), 1'b0)));
    check("addr_zx", 32'(s0_addr), 32'(operand));
  endtask

  // Entered and left at a falling edge; drives, clocks, then compares 1 ns after the edge.
  task automatic step(input logic [1:0] sa, input logic sb, input logic wr,
                      input logic [3:0] o, input logic [10:0] opd, input logic [15:0] dm);
    sel_a = sa; sel_b = sb; wracc = wr; op = o; operand = opd; dm_rd = dm;
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check({tag, "_acc"},  32'(s1_acc),  32'h0);
    check({tag, "_flag"}, 32'({s1_z, s1_n, s1_c, s1_v}), 32'h0);
    check({tag, "_busy"}, 32'(s1_busy), 32'h0);
    check({tag, "_done"}, 32'(s1_done), 32'h0);
    check({tag, "_zx"},   32'({s0_acc, s0_z, s0_n, s0_c, s0_v, s0_busy, s0_done}), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_mul_tail(input string tag, input bit poke, output int busy_seen, output int done_seen);
    busy_seen = (s1_busy === 1'b1) ? 1 : 0;
    done_seen = 0;
    for (int i = 0; i < 16; i++) begin
      step(poke ? 2'($urandom_range(0, 3)) : 2'b11, 1'b1, poke, 4'($urandom_range(0, 15)),
           11'($urandom), 16'($urandom));
      if (s1_busy === 1'b1) busy_seen++;
      if (s1_done === 1'b1) done_seen++;
    end
    check({tag, "_busycyc"}, 32'(busy_seen), 32'd16);
    check({tag, "_donecnt"}, 32'(done_seen), 32'd1);
  endtask

  initial begin
    int busy_seen, done_seen;
    rst = 1'b1; sel_a = 2'b11; sel_b = 1'b0; wracc = 1'b0; op = 4'd0; operand = '0; dm_rd = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_acc",  32'(s1_acc), 32'h0);
    check("rst_flag", 32'({s1_z, s1_n, s1_c, s1_v, s1_busy, s1_done}), 32'h0);
    rst = 1'b0;

    // Immediate extension and ADD wrap-around
    step(2'b01, 1'b0, 1'b1, 4'd0, 11'h7FF, 16'h0);
    check("ld_sext", 32'(s1_acc), 32'hFFFF);
    check("ld_zext", 32'(s0_acc), 32'h07FF);
    step(2'b10, 1'b1, 1'b1, 4'd0, 11'd1, 16'h0);
    check("add_wrap", 32'({s1_acc, s1_z, s1_n, s1_c, s1_v}), 32'({16'h0000, 4'b1010}));

    // Signed overflow on ADD, CMP keeps ACC
    step(2'b00, 1'b0, 1'b1, 4'd0, 11'd0, 16'h7FFF);
    step(2'b10, 1'b0, 1'b1, 4'd0, 11'd0, 16'h0001);
    check("add_ovf", 32'({s1_acc, s1_z, s1_n, s1_c, s1_v}), 32'({16'h8000, 4'b0101}));
    step(2'b00, 1'b0, 1'b1, 4'd0, 11'd0, 16'h0003);
    step(2'b10, 1'b1, 1'b1, 4'd9, 11'd5, 16'h0);
    check("cmp", 32'({s1_acc, s1_z, s1_n, s1_c}), 32'({16'h0003, 3'b011}));

    // Shifts, including amount 0
    step(2'b00, 1'b0, 1'b1, 4'd0, 11'd0, 16'h8001);
    step(2'b10, 1'b1, 1'b1, 4'd6, 11'd1, 16'h0);
    check("shl1", 32'({s1_acc, s1_c}), 32'({16'h0002, 1'b1}));
    step(2'b00, 1'b0, 1'b1, 4'd0, 11'd0, 16'h00F8);
    step(2'b10, 1'b1, 1'b1, 4'd7, 11'd4, 16'h0);
    check("shr4", 32'({s1_acc, s1_c}), 32'({16'h000F, 1'b1}));
    step(2'b10, 1'b1, 1'b1, 4'd6, 11'd0, 16'h0);
    check("shl0", 32'({s1_acc, s1_c}), 32'({16'h000F, 1'b0}));

    // Multiplies; load pulses during busy must be ignored
    step(2'b00, 1'b0, 1'b1, 4'd0, 11'd0, 16'h0123);
    step(2'b10, 1'b1, 1'b1, 4'd8, 11'h010, 16'h0);
    run_mul_tail("mul1", 1'b1, busy_seen, done_seen);
    check("mul1_res", 32'({s1_acc, s1_z, s1_c, s1_v}), 32'({16'h1230, 3'b000}));
    step(2'b00, 1'b0, 1'b1, 4'd0, 11'd0, 16'h1000);
    step(2'b10, 1'b1, 1'b1, 4'd8, 11'h010, 16'h0);
    run_mul_tail("mul2", 1'b1, busy_seen, done_seen);
    check("mul2_res", 32'({s1_acc, s1_z, s1_c, s1_v}), 32'({16'h0000, 3'b111}));

    // Reset during RUN cycle 5 aborts the multiply
    step(2'b00, 1'b0, 1'b1, 4'd0, 11'd0, 16'h0123);
    step(2'b10, 1'b1, 1'b1, 4'd8, 11'h010, 16'h0);
    for (int i = 0; i < 5; i++) step(2'b11, 1'b0, 1'b0, 4'd0, 11'd0, 16'h0);
    async_reset("rst_mul");
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(2'b11, 1'b0, 1'b0, 4'd0, 11'd0, 16'h0);
      if (s1_done === 1'b1) done_seen++;
    end
    check("rst_mul_nodone", 32'(done_seen), 32'd0);
    step(2'b01, 1'b0, 1'b1, 4'd0, 11'd7, 16'h0);
    step(2'b10, 1'b1, 1'b1, 4'd8, 11'd3, 16'h0);
    run_mul_tail("mul3", 1'b0, busy_seen, done_seen);
    check("mul3_res", 32'(s1_acc), 32'd21);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(2'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 9) < 7),
           4'($urandom_range(0, 15)), 11'($urandom), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/datapath_bip3.md
# datapath_bip3

Parametrised accumulator datapath for the BIP-3 processor: a generalisation of the BIP-2 datapath to configurable data and operand widths. Adds an extended ALU (add, sub, logic, shifts, compare) with registered Z/N/C/V flags, plus an iterative shift-add multiplier with a busy/done handshake to the control unit. Sits between the control unit (select/operation/write-enable, immediate operand) and data memory (address, write data, read data).

## Interface
- DATA_W, 16, accumulator / ALU / data-memory word width (≥ 4)
- OPERAND_W, 11, immediate operand and data-memory address width (≤ DATA_W)
- SIGN_EXT, 1, 1 = sign-extend immediate, 0 = zero-extend
- clock_i  in  1  system clock, all state on rising edge
- reset_i  in  1  asynchronous, active-high reset
- selA_i  in  2  ACC source: 00 dm_out_data, 01 extended immediate, 10 ALU result, 11 hold
- selB_i  in  1  ALU operand B: 0 dm_out_data, 1 extended immediate
- WRACC_i  in  1  accumulator write / ALU execute strobe
- op_i  in  4  ALU operation (see Operation)
- operand_i  in  OPERAND_W  immediate / address from control
- dm_out_data  in  DATA_W  data-memory read data
- dm_in_data  out  DATA_W  data-memory write data (= ACC)
- dm_addr  out  OPERAND_W  data-memory address (= operand_i, combinational)
- ext_o  out  DATA_W  extended immediate (combinational)
- flagZ_o, flagN_o, flagC_o, flagV_o  out  1 each  registered flags
- busy_o  out  1  multiplier running; control must stall
- done_o  out  1  one-cycle pulse when a multiply writes ACC

## Operation
- A = ACC, B = selB_i mux. ALU is combinational except MUL.
- op_i: 0000 ADD A+B; 0001 SUB A−B; 0010 AND; 0011 OR; 0100 XOR; 0101 NOT (~A); 0110 SHL A by B[log2(DATA_W)−1:0]; 0111 SHR logical, same amount; 1000 MUL (low DATA_W bits of A×B, unsigned); 1001 CMP (A−B, flags only); 1010–1111 NOP (result = A, flags unchanged).
- Execute = WRACC_i & selA_i==10 & !busy_o. On execute: ACC ← result (except CMP/NOP, ACC unchanged); flags ← new flags (except NOP).
- WRACC_i with selA_i 00/01: ACC loaded, flags unchanged. selA_i 11: no change.
- Flags: Z = (result==0); N = result[DATA_W−1]. ADD: C = carry out, V = signed overflow. SUB/CMP: C = borrow (A<B unsigned), V = signed overflow. AND/OR/XOR/NOT: C=V=0. Shifts: C = last bit shifted out (amount 0 → C=0), V=0. MUL: C=V=1 iff upper DATA_W bits of full product ≠ 0.
- MUL FSM: IDLE → RUN on execute with op 1000: capture multiplicand B and multiplier A, clear product, counter ← 0, busy_o ← 1. RUN: each cycle add shifted multiplicand if current multiplier bit set, shift, counter++. After DATA_W RUN cycles → IDLE: ACC ← low product, flags updated, busy_o ← 0, done_o ← 1 for one cycle.
- While busy_o=1: WRACC_i ignored (no load, no execute); B captured, so operand inputs may change.

## Timing
- Reset (async, any time incl. mid-multiply): ACC=0, all flags 0, busy_o=0, done_o=0, FSM IDLE, counter 0. Multiply aborted, no ACC write.
- Loads and single-cycle ALU ops: ACC/flags visible the cycle after the WRACC_i edge; dm_in_data follows ACC.
- MUL: execute at edge 0; busy_o high after edge 0 through edge DATA_W (DATA_W cycles); ACC, flags, done_o updated at edge DATA_W. Back-to-back MUL may issue on the cycle busy_o falls (done_o high).
- dm_addr, ext_o: combinational from operand_i, no latency.

## Test plan
- Reset: assert reset_i mid-run → ACC=0x0000, Z=N=C=V=0, busy_o=0 immediately (no clock).
- Load imm operand 0x7FF (SIGN_EXT=1) → ACC=0xFFFF; ADD imm 1 → ACC=0x0000, Z=1, C=1, N=0, V=0; repeat with SIGN_EXT=0 → ACC=0x07FF.
- ACC=0x7FFF, ADD mem 0x0001 → ACC=0x8000, N=1, V=1, C=0; ACC=3, CMP imm 5 → ACC=3, N=1, C=1, Z=0.
- ACC=0x8001, SHL imm 1 → ACC=0x0002, C=1; SHR imm 4 on 0x00F8 → 0x000F, C=1; shift by 0 → ACC unchanged, C=0.
- MUL 0x0123 × imm 0x0010 → busy_o high 16 cycles, then ACC=0x1230, done_o one cycle, C=V=0; 0x1000 × 0x0010 → ACC=0x0000, Z=1, C=V=1; WRACC_i load pulses during busy_o → ignored.
- Assert reset_i at RUN cycle 5 of a MUL → busy_o=0, ACC=0, done_o never pulses; next MUL completes normally.
